mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Arbiter and byte-serial sequencer for the single external memory port. Instruction fetch (IF) and the load/store buffer (LSB) each issue one-cycle request pulses. The block queues them, grants the port to one requester at a time, serialises 1/2/4-byte accesses into byte cycles, and returns a one-cycle completion pulse with little-endian assembled data. It sits between IF/LSB and the top-level RAM/IO bus.

## Interface
- No parameters; widths come from `header.vh` (`MEM_ADD_W` = 32, `REG_DAT_W` = 32).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0); clears all state immediately.
- en  in  1  global ready; when 0, all state is frozen and mem_wr is forced to 0.
- iROB_Mp  in  1  misprediction flush.
- iIF_En  in  1  fetch request pulse.
- iIF_Add  in  32  fetch address (4-byte read).
- oIF_En  out  1  fetch done pulse.
- oIF_Dat  out  32  fetched instruction.
- iDC_En  in  1  LSB request pulse.
- iDC_Rw  in  1  0: read, 1: write.
- iDC_Len  in  3  byte count: 1, 2 or 4.
- iDC_Add  in  32  byte address.
- iDC_Dat  in  32  write data (low iDC_Len bytes used).
- oDC_En  out  1  LSB done pulse.
- oDC_Dat  out  32  read data, zero-extended; 0 on writes.
- mem_din  in  8  RAM read byte, valid the cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1: write.
- io_buffer_full  in  1  IO output buffer full.

## Operation
- Outputs are registered. Reset value of every output is 0.
- One pending slot per requester: ifP (address) and dcP (rw, len, address, data). A pulse sets the slot. A pulse that arrives while the slot is full or busy is illegal; requesters never do this.
- FSM states: IDLE, READ, WRITE.
  - IDLE: if dcP is set, grant DC; else if ifP is set, grant IF. DC has strict priority. An ungranted slot is held.
  - The pending slot is consumed into the working registers (addr, len, cnt, buf, owner) on the grant edge.
- READ, byte i = 0..len-1:
  - Drive mem_a = addr+i, mem_wr = 0.
  - On the next edge capture mem_din into buf[8i+7:8i].
  - After the last capture, pulse owner En with buf (upper bytes 0) and return to IDLE.
- WRITE, byte i:
  - Drive mem_a = addr+i, mem_dout = data[8i+7:8i], mem_wr = 1.
  - After the last byte, pulse oDC_En with oDC_Dat = 0 and return to IDLE.
- IO stall: if addr[17:16] == 2'b11 and io_buffer_full = 1 in the WRITE state, drive mem_wr = 0 and do not advance cnt.
- Address arithmetic is 32-bit modulo 2^32; addr+i wraps.
- iROB_Mp:
  - Clears ifP and dcP when dcP is a read.
  - Aborts an in-flight READ (IF or DC) and returns to IDLE with no done pulse.
  - An in-flight WRITE and a pending write are committed stores. They complete normally, but their oDC_En pulse is suppressed.
  - Requests arriving in the same cycle as iROB_Mp are discarded.
- Reset mid-access: the access is abandoned immediately; mem_wr drops to 0 asynchronously.

## Timing
- Edge numbering: a request is sampled at edge 0.
  - Grant occurs at edge 0 if IDLE; the first address is driven in cycle 1.
- Read of N bytes:
  - Addresses in cycles 1..N.
  - Data on mem_din in cycles 2..N+1.
  - Done pulse high in cycle N+2.
  - Example: 4-byte fetch pulse in cycle 6.
- Write of N bytes (no stall): mem_wr = 1 in cycles 1..N; done pulse in cycle N+1.
- Done cycle:
  - mem_a, mem_wr and mem_dout are 0.
  - The FSM is IDLE at the end of the done cycle.
  - A queued request starts addressing in the following cycle.
- Request and grant in the same cycle: a pulse sampled at edge 0 while IDLE is granted at edge 0 (bypass of the pending slot).
- Simultaneous IF and DC pulses at IDLE: DC is granted. IF waits and starts the cycle after DC's done pulse.
- Done pulses last exactly one cycle; data is valid only while the pulse is high.

## Test plan
- LW at 0x100, RAM bytes 0x13,0x05,0x10,0x00 → oDC_En in cycle 6 with oDC_Dat = 0x00100513; mem_a = 0x100..0x103 in cycles 1–4.
- SH 0x1234ABCD to 0x200 → mem_wr = 1 in cycles 1–2, bytes 0xCD then 0xAB; oDC_En in cycle 3; oDC_Dat = 0.
- IF 0x0 and DC LB 0x40 pulsed together → DC read first, done in cycle 3; IF addresses 0x0..0x3 in cycles 4–7; oIF_En in cycle 9.
- SB 0x41 to 0x30000 with io_buffer_full = 1 for cycles 1–3 → mem_wr = 0 in cycles 1–3, write in cycle 4, oDC_En in cycle 5.
- iROB_Mp in cycle 3 of a 4-byte fetch → no oIF_En; mem_a = 0 in cycle 4. iROB_Mp during an SW → all 4 bytes are written and no oDC_En pulse occurs.
- rst = 0 asserted mid-write, asynchronous to clk → mem_wr = 0 immediately. After release, a new LW completes at standard latency.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - IF/LSB arbiter and byte-serial sequencer for the external memory port
// DC has strict priority; each requester owns one pending slot that is bypassed when the port is idle.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        iROB_Mp,
  input  logic        iIF_En,
  input  logic [31:0] iIF_Add,
  output logic        oIF_En,
  output logic [31:0] oIF_Dat,
  input  logic        iDC_En,
  input  logic        iDC_Rw,
  input  logic [2:0]  iDC_Len,
  input  logic [31:0] iDC_Add,
  input  logic [31:0] iDC_Dat,
  output logic        oDC_En,
  output logic [31:0] oDC_Dat,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;

  logic        if_pv;
  logic [31:0] if_pa;
  logic        dc_pv, dc_prw, dc_pq;
  logic [2:0]  dc_plen;
  logic [31:0] dc_pa, dc_pd;

  logic        owner_dc, quiet, io_w, wr_q;
  logic [2:0]  len, cnt;
  logic [31:0] rbuf, wdat;

  logic        take_dc, take_if, g_rw, g_q;
  logic [2:0]  g_len;
  logic [31:0] g_a, g_d;
  logic        stall;
  logic [2:0]  cnt_m1;
  logic [31:0] rd_word;

  // Under a flush only a committed (write) pending store may still be granted.
  always_comb begin
    take_dc = iROB_Mp ? (dc_pv && dc_prw) : (dc_pv || iDC_En);
    take_if = !take_dc && !iROB_Mp && (if_pv || iIF_En);
    g_rw    = dc_pv ? dc_prw  : iDC_Rw;
    g_len   = dc_pv ? dc_plen : iDC_Len;
    g_d     = dc_pv ? dc_pd   : iDC_Dat;
    g_a     = take_dc ? (dc_pv ? dc_pa : iDC_Add) : (if_pv ? if_pa : iIF_Add);
    g_q     = dc_pv && (dc_pq || iROB_Mp);
  end

  assign stall  = (state == WRITE) && io_w && io_buffer_full;
  assign mem_wr = wr_q && en && !stall;

  always_comb begin
    cnt_m1  = cnt - 3'd1;
    rd_word = rbuf;
    rd_word[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      if_pv    <= 1'b0;
      if_pa    <= '0;
      dc_pv    <= 1'b0;
      dc_prw   <= 1'b0;
      dc_pq    <= 1'b0;
      dc_plen  <= '0;
      dc_pa    <= '0;
      dc_pd    <= '0;
      owner_dc <= 1'b0;
      quiet    <= 1'b0;
      io_w     <= 1'b0;
      wr_q     <= 1'b0;
      len      <= '0;
      cnt      <= '0;
      rbuf     <= '0;
      wdat     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      oIF_En   <= 1'b0;
      oIF_Dat  <= '0;
      oDC_En   <= 1'b0;
      oDC_Dat  <= '0;
    end else if (en) begin
      oIF_En  <= 1'b0;
      oDC_En  <= 1'b0;
      oIF_Dat <= '0;
      oDC_Dat <= '0;

      if (iROB_Mp || (state == IDLE && take_if)) begin
        if_pv <= 1'b0;
      end else if (iIF_En) begin
        if_pv <= 1'b1;
        if_pa <= iIF_Add;
      end

      if (state == IDLE && take_dc) begin
        dc_pv <= 1'b0;
      end else if (iROB_Mp) begin
        if (!dc_prw) dc_pv <= 1'b0;
        dc_pq <= 1'b1;
      end else if (iDC_En) begin
        dc_pv   <= 1'b1;
        dc_prw  <= iDC_Rw;
        dc_plen <= iDC_Len;
        dc_pa   <= iDC_Add;
        dc_pd   <= iDC_Dat;
        dc_pq   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (take_dc || take_if) begin
            owner_dc <= take_dc;
            len      <= take_dc ? g_len : 3'd4;
            cnt      <= '0;
            rbuf     <= '0;
            mem_a    <= g_a;
            quiet    <= take_dc && g_q;
            io_w     <= (g_a[17:16] == 2'b11);
            if (take_dc && g_rw) begin
              state    <= WRITE;
              wr_q     <= 1'b1;
              mem_dout <= g_d[7:0];
              wdat     <= g_d >> 8;
            end else begin
              state <= READ;
              wr_q  <= 1'b0;
            end
          end
        end
        // cnt counts edges since grant; byte cnt-1 is on mem_din at each edge from the second on.
        READ: begin
          if (iROB_Mp) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            if (cnt != 3'd0) rbuf <= rd_word;
            if (cnt == len) begin
              state <= IDLE;
              mem_a <= '0;
              if (owner_dc) begin
                oDC_En  <= 1'b1;
                oDC_Dat <= rd_word;
              end else begin
                oIF_En  <= 1'b1;
                oIF_Dat <= rd_word;
              end
            end else begin
              cnt   <= cnt + 3'd1;
              mem_a <= (cnt + 3'd1 < len) ? mem_a + 32'd1 : '0;
            end
          end
        end
        WRITE: begin
          if (iROB_Mp) quiet <= 1'b1;
          if (!stall) begin
            if (cnt + 3'd1 == len) begin
              state    <= IDLE;
              wr_q     <= 1'b0;
              mem_a    <= '0;
              mem_dout <= '0;
              oDC_En   <= !(quiet || iROB_Mp);
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= mem_a + 32'd1;
              mem_dout <= wdat[7:0];
              wdat     <= wdat >> 8;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        iROB_Mp = 1'b0;
  logic        iIF_En = 1'b0;
  logic [31:0] iIF_Add = '0;
  logic        oIF_En;
  logic [31:0] oIF_Dat;
  logic        iDC_En = 1'b0;
  logic        iDC_Rw = 1'b0;
  logic [2:0]  iDC_Len = '0;
  logic [31:0] iDC_Add = '0;
  logic [31:0] iDC_Dat = '0;
  logic        oDC_En;
  logic [31:0] oDC_Dat;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  logic [7:0] ram [0:4095];
  int total = 0;
  int bad = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .iROB_Mp(iROB_Mp),
    .iIF_En(iIF_En), .iIF_Add(iIF_Add), .oIF_En(oIF_En), .oIF_Dat(oIF_Dat),
    .iDC_En(iDC_En), .iDC_Rw(iDC_Rw), .iDC_Len(iDC_Len), .iDC_Add(iDC_Add),
    .iDC_Dat(iDC_Dat), .oDC_En(oDC_En), .oDC_Dat(oDC_Dat),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM returns the byte for the address driven in the previous cycle.
  always @(posedge clk) mem_din <= ram[mem_a[11:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    iIF_En = 1'b0;
    iDC_En = 1'b0;
  endtask

  task automatic dc_req(input logic rw, input logic [2:0] n, input logic [31:0] a, input logic [31:0] d);
    iDC_En  = 1'b1;
    iDC_Rw  = rw;
    iDC_Len = n;
    iDC_Add = a;
    iDC_Dat = d;
  endtask

  task automatic lw_check(input string nm);
    dc_req(1'b0, 3'd4, 32'h100, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      nxt();
      if (k == 1) clr();
      @(negedge clk);
      check($sformatf("%s_a c%0d", nm, k), mem_a, (k <= 4) ? 32'h100 + 32'(k - 1) : 32'h0);
      check($sformatf("%s_wr c%0d", nm, k), {31'b0, mem_wr}, 32'h0);
      check($sformatf("%s_en c%0d", nm, k), {31'b0, oDC_En}, {31'b0, k == 6});
      if (k == 6) check($sformatf("%s_dat", nm), oDC_Dat, 32'h00100513);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = i[7:0] ^ 8'h5A;
    ram[12'h100] = 8'h13;
    ram[12'h101] = 8'h05;
    ram[12'h102] = 8'h10;
    ram[12'h103] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a", mem_a, 32'h0);
    check("rst_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_dout", {24'b0, mem_dout}, 32'h0);
    check("rst_ifen", {31'b0, oIF_En}, 32'h0);
    check("rst_dcen", {31'b0, oDC_En}, 32'h0);
    check("rst_dcdat", oDC_Dat, 32'h0);
    nxt();
    rst = 1'b1;
    nxt();

    lw_check("lw");
    nxt();

    // SH 0x1234ABCD to 0x200
    dc_req(1'b1, 3'd2, 32'h200, 32'h1234ABCD);
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 1) clr();
      @(negedge clk);
      check($sformatf("sh_wr c%0d", k), {31'b0, mem_wr}, {31'b0, k <= 2});
      check($sformatf("sh_a c%0d", k), mem_a, (k <= 2) ? 32'h200 + 32'(k - 1) : 32'h0);
      check($sformatf("sh_dout c%0d", k), {24'b0, mem_dout}, (k == 1) ? 32'hCD : (k == 2) ? 32'hAB : 32'h0);
      check($sformatf("sh_en c%0d", k), {31'b0, oDC_En}, {31'b0, k == 3});
      if (k == 3) check("sh_dat", oDC_Dat, 32'h0);
    end
    nxt();

    // IF 0x0 and LB 0x40 together
    dc_req(1'b0, 3'd1, 32'h40, 32'h0);
    iIF_En = 1'b1;
    iIF_Add = 32'h0;
    for (int k = 1; k <= 9; k++) begin
      nxt();
      if (k == 1) clr();
      @(negedge clk);
      check($sformatf("arb_a c%0d", k), mem_a, (k == 1) ? 32'h40 : (k >= 4 && k <= 7) ? 32'(k - 4) : 32'h0);
      check($sformatf("arb_dcen c%0d", k), {31'b0, oDC_En}, {31'b0, k == 3});
      check($sformatf("arb_ifen c%0d", k), {31'b0, oIF_En}, {31'b0, k == 9});
      if (k == 3) check("arb_dcdat", oDC_Dat, 32'h0000001A);
      if (k == 9) check("arb_ifdat", oIF_Dat, 32'h59585B5A);
    end
    nxt();

    // SB 0x41 to IO space with a full IO buffer for cycles 1-3
    dc_req(1'b1, 3'd1, 32'h30000, 32'h41);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      if (k == 1) clr();
      io_buffer_full = (k <= 3);
      @(negedge clk);
      check($sformatf("io_wr c%0d", k), {31'b0, mem_wr}, {31'b0, k == 4});
      check($sformatf("io_en c%0d", k), {31'b0, oDC_En}, {31'b0, k == 5});
      if (k == 4) begin
        check("io_a", mem_a, 32'h30000);
        check("io_dout", {24'b0, mem_dout}, 32'h41);
      end
    end
    io_buffer_full = 1'b0;
    nxt();

    // Fetch flushed in cycle 3
    iIF_En = 1'b1;
    iIF_Add = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      if (k == 1) clr();
      iROB_Mp = (k == 3);
      @(negedge clk);
      check($sformatf("mpf_a c%0d", k), mem_a, (k <= 3) ? 32'(k - 1) : 32'h0);
      check($sformatf("mpf_ifen c%0d", k), {31'b0, oIF_En}, 32'h0);
    end
    iROB_Mp = 1'b0;
    nxt();

    // SW flushed in cycle 2 still writes all bytes, silently
    dc_req(1'b1, 3'd4, 32'h300, 32'h11223344);
    for (int k = 1; k <= 7; k++) begin
      nxt();
      if (k == 1) clr();
      iROB_Mp = (k == 2);
      @(negedge clk);
      check($sformatf("mpw_wr c%0d", k), {31'b0, mem_wr}, {31'b0, k <= 4});
      if (k <= 4) check($sformatf("mpw_dout c%0d", k), {24'b0, mem_dout}, 32'h44 - 32'(k - 1) * 32'h11);
      check($sformatf("mpw_en c%0d", k), {31'b0, oDC_En}, 32'h0);
    end
    iROB_Mp = 1'b0;
    nxt();

    // LH across the top of the address space
    dc_req(1'b0, 3'd2, 32'hFFFFFFFF, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      if (k == 1) clr();
      @(negedge clk);
      check($sformatf("wrap_a c%0d", k), mem_a, (k == 1) ? 32'hFFFFFFFF : 32'h0);
      check($sformatf("wrap_en c%0d", k), {31'b0, oDC_En}, {31'b0, k == 4});
      if (k == 4) check("wrap_dat", oDC_Dat, 32'h00005AA5);
    end
    nxt();

    // LB 0x41 with en low in cycles 1-2
    dc_req(1'b0, 3'd1, 32'h41, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      if (k == 1) clr();
      en = !(k == 1 || k == 2);
      @(negedge clk);
      check($sformatf("en_a c%0d", k), mem_a, (k <= 3) ? 32'h41 : 32'h0);
      check($sformatf("en_en c%0d", k), {31'b0, oDC_En}, {31'b0, k == 5});
      if (k == 5) check("en_dat", oDC_Dat, 32'h0000001B);
    end
    en = 1'b1;
    nxt();

    // Asynchronous reset in the middle of a write
    dc_req(1'b1, 3'd4, 32'h300, 32'h11223344);
    nxt();
    clr();
    nxt();
    @(negedge clk);
    check("arst_pre_wr", {31'b0, mem_wr}, 32'h1);
    #1 rst = 1'b0;
    #1;
    check("arst_wr", {31'b0, mem_wr}, 32'h0);
    check("arst_a", mem_a, 32'h0);
    nxt();
    rst = 1'b1;
    nxt();
    lw_check("lw2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
